// File: rtl/depth_core_scheduler.sv
// Frame scheduler for a bank of Mandelbrot depth engines.
// Round-robin issue to idle cores, strict in-order retire.
module depth_core_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int COLOR_W   = 24
) (
  input  logic                         sysclk,
  input  logic                         reset,
  input  logic                         frame_start,
  output logic                         busy,
  output logic                         frame_done,
  input  logic                         src_valid,
  output logic                         src_ready,
  input  logic [9:0]                   src_x,
  input  logic [8:0]                   src_y,
  input  logic [31:0]                  src_re,
  input  logic [31:0]                  src_im,
  output logic [NUM_CORES-1:0]         core_start,
  output logic [NUM_CORES*10-1:0]      core_x,
  output logic [NUM_CORES*9-1:0]       core_y,
  output logic [NUM_CORES*32-1:0]      core_re,
  output logic [NUM_CORES*32-1:0]      core_im,
  input  logic [NUM_CORES-1:0]         core_done,
  input  logic [NUM_CORES*COLOR_W-1:0] core_color,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [9:0]                   out_x,
  output logic [8:0]                   out_y,
  output logic [COLOR_W-1:0]           out_color
);

  localparam int PW = $clog2(NUM_CORES);
  localparam logic [18:0] TOTAL = 19'(H_RES * V_RES);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_nx;

  logic [PW-1:0]        issue_ptr, retire_ptr;
  logic [18:0]          issued, retired;
  logic [NUM_CORES-1:0] slot_busy, res_valid;
  logic [9:0]           sx [NUM_CORES];
  logic [8:0]           sy [NUM_CORES];
  logic [31:0]          sre [NUM_CORES];
  logic [31:0]          sim [NUM_CORES];
  logic [COLOR_W-1:0]   scol [NUM_CORES];

  logic accept, retire, last_issue, last_retire;

  assign src_ready = (state == RUN)
                   & ~slot_busy[issue_ptr]
                   & ~res_valid[issue_ptr]
                   & (issued < TOTAL);
  assign accept      = src_valid & src_ready;
  assign out_valid   = res_valid[retire_ptr];
  assign retire      = out_valid & out_ready;
  assign last_issue  = accept & (issued == TOTAL - 19'd1);
  assign last_retire = retire & (retired == TOTAL - 19'd1);
  assign out_x       = sx[retire_ptr];
  assign out_y       = sy[retire_ptr];
  assign out_color   = scol[retire_ptr];
  assign busy        = (state != IDLE);
  assign frame_done  = (state == DRAIN) & last_retire;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (frame_start) state_nx = RUN;
      RUN:     if (last_issue) state_nx = DRAIN;
      DRAIN:   if (last_retire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      issue_ptr  <= '0;
      retire_ptr <= '0;
      issued     <= '0;
      retired    <= '0;
      core_start <= '0;
    end else begin
      core_start <= '0;
      if (state == IDLE && frame_start) begin
        issue_ptr  <= '0;
        retire_ptr <= '0;
        issued     <= '0;
        retired    <= '0;
      end
      if (accept) begin
        issued                <= issued + 19'd1;
        issue_ptr             <= issue_ptr + 1'b1;
        core_start[issue_ptr] <= 1'b1;
      end
      if (retire) begin
        retired    <= retired + 19'd1;
        retire_ptr <= retire_ptr + 1'b1;
      end
    end
  end

  // Issue only targets free slots and done only hits busy ones,
  // so the per-slot updates below never collide.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      slot_busy <= '0;
      res_valid <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        sx[i]   <= '0;
        sy[i]   <= '0;
        sre[i]  <= '0;
        sim[i]  <= '0;
        scol[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (accept && issue_ptr == PW'(i)) begin
          slot_busy[i] <= 1'b1;
          sx[i]        <= src_x;
          sy[i]        <= src_y;
          sre[i]       <= src_re;
          sim[i]       <= src_im;
        end else if (core_done[i] && slot_busy[i]) begin
          slot_busy[i] <= 1'b0;
          res_valid[i] <= 1'b1;
          scol[i]      <= core_color[i*COLOR_W +: COLOR_W];
        end
        if (retire && retire_ptr == PW'(i))
          res_valid[i] <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    assign core_x[g*10 +: 10]  = sx[g];
    assign core_y[g*9 +: 9]    = sy[g];
    assign core_re[g*32 +: 32] = sre[g];
    assign core_im[g*32 +: 32] = sim[g];
  end

endmodule

// File: tb/tb_depth_core_scheduler.sv
// Scoreboard bench for depth_core_scheduler on a 4x2 frame.
// Behavioural cores with per-core latency drive core_done/core_color.
module tb_depth_core_scheduler;

  localparam int NC   = 4;
  localparam int H    = 4;
  localparam int V    = 2;
  localparam int CW   = 24;
  localparam int NPIX = H * V;

  logic sysclk = 0;
  logic reset = 1;
  logic frame_start = 0;
  logic busy, frame_done;
  logic src_valid = 0;
  logic src_ready;
  logic [9:0] src_x = '0;
  logic [8:0] src_y = '0;
  logic [31:0] src_re = '0;
  logic [31:0] src_im = '0;
  logic [NC-1:0] core_start;
  logic [NC*10-1:0] core_x;
  logic [NC*9-1:0] core_y;
  logic [NC*32-1:0] core_re, core_im;
  logic [NC-1:0] core_done;
  logic [NC*CW-1:0] core_color;
  logic out_valid;
  logic out_ready = 0;
  logic [9:0] out_x;
  logic [8:0] out_y;
  logic [CW-1:0] out_color;

  logic [NC-1:0] model_done = '0;
  logic [NC-1:0] spur = '0;
  logic [NC*CW-1:0] model_color = '0;
  logic [NC*CW-1:0] spur_color = '0;

  assign core_done  = model_done | spur;
  assign core_color = model_color | spur_color;

  depth_core_scheduler #(
    .NUM_CORES(NC), .H_RES(H), .V_RES(V), .COLOR_W(CW)
  ) dut (
    .sysclk(sysclk), .reset(reset), .frame_start(frame_start),
    .busy(busy), .frame_done(frame_done),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_x(src_x), .src_y(src_y), .src_re(src_re), .src_im(src_im),
    .core_start(core_start), .core_x(core_x), .core_y(core_y),
    .core_re(core_re), .core_im(core_im),
    .core_done(core_done), .core_color(core_color),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_color(out_color)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  function automatic logic [CW-1:0] colfn(input logic [9:0] x,
                                          input logic [8:0] y);
    return {5'h15, y, x};
  endfunction

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural depth engines
  int lat [NC];
  int cnt [NC];
  bit act [NC];

  always @(negedge sysclk) begin
    for (int i = 0; i < NC; i++) begin
      model_done[i] = 1'b0;
      if (reset) act[i] = 0;
      else begin
        if (act[i]) begin
          if (cnt[i] == 0) begin
            model_done[i] = 1'b1;
            model_color[i*CW +: CW] =
              colfn(core_x[i*10 +: 10], core_y[i*9 +: 9]);
            act[i] = 0;
          end else cnt[i]--;
        end
        if (core_start[i]) begin
          act[i] = 1;
          cnt[i] = lat[i];
        end
      end
    end
  end

  typedef struct packed {
    logic [9:0]    x;
    logic [8:0]    y;
    logic [CW-1:0] c;
  } exp_t;

  exp_t q[$];
  int n_acc = 0, n_ret = 0, fr_cnt = 0, fd_cnt = 0;
  int acc_cyc [64];
  int ret_cyc [64];

  always @(negedge sysclk) begin
    exp_t e;
    if (reset) q.delete();
    else begin
      if (src_valid && src_ready) begin
        q.push_back('{x: src_x, y: src_y, c: colfn(src_x, src_y)});
        if (n_acc < 64) acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("retire_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          chk("out_x", 64'(out_x), 64'(e.x));
          chk("out_y", 64'(out_y), 64'(e.y));
          chk("out_color", 64'(out_color), 64'(e.c));
        end
        if (n_ret < 64) ret_cyc[n_ret] = cyc;
        n_ret++;
        fr_cnt++;
        chk("frame_done_at_retire", 64'(frame_done), 64'(fr_cnt == NPIX));
      end else if (frame_done) chk("frame_done_stray", 1, 0);
      if (frame_done) fd_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic start_frame();
    n_acc = 0; n_ret = 0; fr_cnt = 0; fd_cnt = 0;
    frame_start = 1;
    tick(1);
    frame_start = 0;
  endtask

  task automatic send_pix(input int idx);
    int k;
    src_valid = 1;
    src_x  = 10'(idx % H);
    src_y  = 9'(idx / H);
    src_re = 32'h1000_0000 + 32'(idx);
    src_im = -32'(idx);
    k = 0;
    forever begin
      @(negedge sysclk);
      if (src_ready) break;
      k++;
      if (k > 300) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge sysclk);
    #1;
    src_valid = 0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    forever begin
      @(negedge sysclk);
      if (!busy && q.size() == 0) break;
      k++;
      if (k > 2000) begin
        chk("idle_timeout", 0, 1);
        break;
      end
    end
    tick(1);
  endtask

  initial begin
    logic [9:0] hx;
    logic [8:0] hy;
    logic [CW-1:0] hc;
    int changes, k;
    for (int i = 0; i < NC; i++) lat[i] = 50;

    // reset state
    tick(3);
    @(negedge sysclk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_src_ready", 64'(src_ready), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_core_start", 64'(core_start), 0);
    chk("rst_frame_done", 64'(frame_done), 0);
    tick(1);
    reset = 0;
    tick(1);

    // reset mid-RUN with 3 cores busy
    out_ready = 1;
    start_frame();
    for (int p = 0; p < 3; p++) send_pix(p);
    tick(2);
    reset = 1;
    tick(1);
    @(negedge sysclk);
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_out_valid", 64'(out_valid), 0);
    chk("midrst_core_start", 64'(core_start), 0);
    chk("midrst_src_ready", 64'(src_ready), 0);
    tick(1);
    reset = 0;
    tick(1);

    // ordering with latencies 40/10/25/5, full-slot stall,
    // frame_start ignored in RUN and DRAIN
    lat[0] = 40; lat[1] = 10; lat[2] = 25; lat[3] = 5;
    start_frame();
    send_pix(0);
    chk("restart_ptr0", 64'(core_start), 64'b0001);
    send_pix(1);
    send_pix(2);
    send_pix(3);
    chk("core2_x", 64'(core_x[2*10 +: 10]), 2);
    chk("core1_re", 64'(core_re[1*32 +: 32]), 64'h1000_0001);
    chk("core3_im", 64'(core_im[3*32 +: 32]), 64'hFFFF_FFFD);
    lat[0] = 3; lat[1] = 3; lat[2] = 3;
    send_pix(4);
    chk("stall_waited", 64'(acc_cyc[4] > acc_cyc[3] + 10), 1);
    chk("issue_after_retire", 64'(acc_cyc[4]), 64'(ret_cyc[0] + 1));
    chk("retire0_first_x", 64'(n_ret >= 1), 1);
    frame_start = 1;
    send_pix(5);
    frame_start = 0;
    send_pix(6);
    send_pix(7);
    frame_start = 1;
    tick(2);
    frame_start = 0;
    wait_idle();
    chk("f1_accepts", 64'(n_acc), NPIX);
    chk("f1_retires", 64'(n_ret), NPIX);
    chk("f1_frame_done", 64'(fd_cnt), 1);
    tick(5);
    chk("f1_no_restart", 64'(busy), 0);
    chk("f1_no_extra_out", 64'(n_ret), NPIX);

    // downstream backpressure
    lat[3] = 3;
    out_ready = 0;
    start_frame();
    for (int p = 0; p < 4; p++) send_pix(p);
    k = 0;
    while (!out_valid && k < 200) begin
      @(negedge sysclk);
      k++;
    end
    chk("bp_out_valid", 64'(out_valid), 1);
    hx = out_x; hy = out_y; hc = out_color;
    changes = 0;
    repeat (20) begin
      @(negedge sysclk);
      if (!out_valid || out_x !== hx || out_y !== hy || out_color !== hc)
        changes++;
    end
    chk("bp_hold_stable", 64'(changes), 0);
    chk("bp_no_retire", 64'(n_ret), 0);
    chk("bp_no_reissue", 64'(n_acc), 4);
    chk("bp_src_ready", 64'(src_ready), 0);
    tick(1);
    out_ready = 1;
    for (int p = 4; p < NPIX; p++) send_pix(p);
    wait_idle();
    chk("f2_retires", 64'(n_ret), NPIX);
    chk("f2_frame_done", 64'(fd_cnt), 1);

    // spurious done on idle core 2
    spur[2] = 1;
    spur_color[2*CW +: CW] = 24'hDEAD01;
    tick(1);
    spur = '0;
    spur_color = '0;
    changes = 0;
    repeat (3) begin
      @(negedge sysclk);
      if (out_valid) changes++;
    end
    chk("spur_no_output", 64'(changes), 0);
    chk("spur_busy", 64'(busy), 0);
    tick(1);

    // full frame after spurious done, mixed latencies
    lat[0] = 7; lat[1] = 2; lat[2] = 9; lat[3] = 1;
    start_frame();
    for (int p = 0; p < NPIX; p++) send_pix(p);
    wait_idle();
    chk("f3_retires", 64'(n_ret), NPIX);
    chk("f3_frame_done", 64'(fd_cnt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
